// File: rtl/quant_scheduler_if.sv
// quant_scheduler_if: handshake bundle between the quantizer scheduler and its block sources, quantizer and downstream
// Signals: req/gnt/q_enable/q_sel (issue side), q_out_enable/res_valid/res_comp (result side),
//          dn_ready, flush/flush_done, busy, tag_err (control and status).
// Modports: master = scheduler, slave = surrounding datapath.
interface quant_scheduler_if;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       q_enable;
    logic [1:0] q_sel;
    logic       q_out_enable;
    logic       dn_ready;
    logic       res_valid;
    logic [1:0] res_comp;
    logic       flush;
    logic       flush_done;
    logic       busy;
    logic       tag_err;
    modport master (
        input  req, q_out_enable, dn_ready, flush,
        output gnt, q_enable, q_sel, res_valid, res_comp, flush_done, busy, tag_err
    );
    modport slave (
        output req, q_out_enable, dn_ready, flush,
        input  gnt, q_enable, q_sel, res_valid, res_comp, flush_done, busy, tag_err
    );
endinterface

// File: rtl/quant_scheduler.sv
// quant_scheduler: round-robin issue of Y/Cb/Cr blocks to a shared 8x8 quantizer with result tagging and flush/drain
// Ports: clk, rst (synchronous, active-high); bus (quant_scheduler_if.master): req in, gnt/q_enable/q_sel out,
//        q_out_enable in, res_valid/res_comp out, dn_ready in, flush in, flush_done/busy/tag_err out.
// Option: define QSCHED_STATS_EN to add 16-bit wrapping per-component grant counters cnt_y, cnt_cb, cnt_cr.
module quant_scheduler #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef QSCHED_STATS_EN
    output logic [15:0] cnt_y,
    output logic [15:0] cnt_cb,
    output logic [15:0] cnt_cr,
`endif
    quant_scheduler_if.master bus
);
    localparam int CW = $clog2(LATENCY + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t             state_q, state_d;
    logic [1:0]         ptr_q, n1, n2, pick, q_sel_q;
    logic [2:0]         eff, gnt_q, gnt_d;
    logic               q_enable_q, flush_done_q, tag_err_q, issue, res_valid;
    logic [CW-1:0]      infl_q, infl_d;
    logic [LATENCY-1:0] tv_q;
    logic [1:0]         tc_q [LATENCY];
    // The component shown on gnt this cycle may still hold req; it must not win again.
    assign eff       = bus.req & ~gnt_q;
    assign n1        = ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1;
    assign n2        = n1 == 2'd2 ? 2'd0 : n1 + 2'd1;
    assign pick      = eff[n1] ? n1 : (eff[n2] ? n2 : ptr_q);
    assign issue     = state_q == RUN && bus.dn_ready && !bus.flush && |eff;
    assign gnt_d     = issue ? 3'b001 << pick : 3'b000;
    assign res_valid = bus.q_out_enable && tv_q[LATENCY-1];
    assign infl_d    = q_enable_q && !res_valid ? infl_q + CW'(1) :
                       (!q_enable_q && res_valid ? infl_q - CW'(1) : infl_q);
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.flush ? DRAIN : (|bus.req ? RUN : IDLE);
            RUN:     state_d = bus.flush ? DRAIN : (bus.req == 3'b000 && infl_q == '0 ? IDLE : RUN);
            DRAIN:   state_d = infl_q == '0 ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd2;
            gnt_q        <= 3'b000;
            q_enable_q   <= 1'b0;
            q_sel_q      <= 2'd0;
            flush_done_q <= 1'b0;
            tag_err_q    <= 1'b0;
            infl_q       <= '0;
            tv_q         <= '0;
            for (int i = 0; i < LATENCY; i++) tc_q[i] <= 2'd0;
        end else begin
            state_q      <= state_d;
            if (issue) ptr_q <= pick;
            gnt_q        <= gnt_d;
            q_enable_q   <= issue;
            q_sel_q      <= issue ? pick : 2'd0;
            flush_done_q <= state_q == DRAIN && infl_q == '0;
            tag_err_q    <= tag_err_q | (bus.q_out_enable && !tv_q[LATENCY-1]);
            infl_q       <= infl_d;
            // Tag pipeline mirrors the quantizer latency; the tail lines up with q_out_enable.
            tv_q         <= (tv_q << 1) | LATENCY'(q_enable_q);
            tc_q[0]      <= q_sel_q;
            for (int i = 1; i < LATENCY; i++) tc_q[i] <= tc_q[i-1];
        end
    end
`ifdef QSCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_y  <= 16'd0;
            cnt_cb <= 16'd0;
            cnt_cr <= 16'd0;
        end else begin
            cnt_y  <= cnt_y + {15'd0, gnt_d[0]};
            cnt_cb <= cnt_cb + {15'd0, gnt_d[1]};
            cnt_cr <= cnt_cr + {15'd0, gnt_d[2]};
        end
    end
`endif
    assign bus.gnt        = gnt_q;
    assign bus.q_enable   = q_enable_q;
    assign bus.q_sel      = q_sel_q;
    assign bus.res_valid  = res_valid;
    assign bus.res_comp   = tc_q[LATENCY-1];
    assign bus.flush_done = flush_done_q;
    assign bus.busy       = infl_q != '0;
    assign bus.tag_err    = tag_err_q;
endmodule

// File: tb/tb_quant_scheduler.sv
// tb_quant_scheduler: random and directed stimulus against a queue-based reference of the scheduler and quantizer
module tb_quant_scheduler;
    localparam int L = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    int m_mode, last, eg, cyc;
    bit ed, etag;
    int due[$];
    int cmp[$];
    logic [2:0] pend;
    logic [15:0] m_cnt [3];
`ifdef QSCHED_STATS_EN
    logic [15:0] cnt_y, cnt_cb, cnt_cr;
`endif
    quant_scheduler_if qif ();
    quant_scheduler #(.LATENCY(L)) dut (
        .clk(clk),
        .rst(rst),
`ifdef QSCHED_STATS_EN
        .cnt_y(cnt_y),
        .cnt_cb(cnt_cb),
        .cnt_cr(cnt_cr),
`endif
        .bus(qif)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask
    task automatic model_reset();
        m_mode = 0;
        last = 2;
        eg = -1;
        ed = 0;
        etag = 0;
        due.delete();
        cmp.delete();
        for (int i = 0; i < 3; i++) m_cnt[i] = 16'd0;
    endtask
    // One clock cycle: drive inputs, check outputs, then advance the reference by one cycle.
    // Modes: 0 idle, 1 run, 2 drain, 3 done.
    task automatic step(input logic [2:0] r, input int f, input int d, input int fq, input int rs);
        bit hit, qoe;
        int n, ng, c;
        logic [2:0] eff;
        @(negedge clk);
        hit = due.size() > 0 ? due[0] == cyc : 1'b0;
        qoe = hit || fq != 0;
        qif.req = r;
        qif.flush = f != 0;
        qif.dn_ready = d != 0;
        qif.q_out_enable = qoe;
        rst = rs != 0;
        #1;
        check("gnt", 16'(qif.gnt), eg < 0 ? 16'd0 : 16'(1 << eg));
        check("q_enable", 16'(qif.q_enable), 16'(eg >= 0));
        check("q_sel", 16'(qif.q_sel), 16'(eg < 0 ? 0 : eg));
        check("res_valid", 16'(qif.res_valid), 16'(hit));
        if (hit) check("res_comp", 16'(qif.res_comp), 16'(cmp[0]));
        check("busy", 16'(qif.busy), 16'(due.size() != 0));
        check("flush_done", 16'(qif.flush_done), 16'(ed));
        check("tag_err", 16'(qif.tag_err), 16'(etag));
`ifdef QSCHED_STATS_EN
        check("cnt_y", cnt_y, m_cnt[0]);
        check("cnt_cb", cnt_cb, m_cnt[1]);
        check("cnt_cr", cnt_cr, m_cnt[2]);
`endif
        if (rs != 0) model_reset();
        else begin
            n = due.size();
            eff = r & (eg < 0 ? 3'b111 : ~3'(1 << eg));
            ng = -1;
            if (m_mode == 1 && d != 0 && f == 0)
                for (int o = 1; o <= 3; o++) begin
                    c = (last + o) % 3;
                    if (ng < 0 && eff[c]) ng = c;
                end
            if (ng >= 0) begin
                last = ng;
                m_cnt[ng] = m_cnt[ng] + 16'd1;
            end
            ed = m_mode == 2 && n == 0;
            case (m_mode)
                0: m_mode = f != 0 ? 2 : (r != 0 ? 1 : 0);
                1: m_mode = f != 0 ? 2 : (r == 0 && n == 0 ? 0 : 1);
                2: m_mode = n == 0 ? 3 : 2;
                default: m_mode = 0;
            endcase
            if (qoe && !hit) etag = 1;
            if (hit) begin
                void'(due.pop_front());
                void'(cmp.pop_front());
            end
            if (eg >= 0) begin
                due.push_back(cyc + L);
                cmp.push_back(eg);
            end
            eg = ng;
        end
        cyc++;
    endtask
    // Requesters hold req until granted and drop it in the grant cycle.
    task automatic agents(input int cycles, input int density, input int f_rand, input int d_rand);
        logic [2:0] gb, nw;
        for (int i = 0; i < cycles; i++) begin
            gb = eg >= 0 ? 3'(1 << eg) : 3'b000;
            nw = $urandom_range(0, 99) < density ? 3'($urandom_range(1, 7)) : 3'b000;
            pend = (pend | nw) & ~gb;
            step(pend, f_rand != 0 && $urandom_range(0, 29) == 0 ? 1 : 0,
                 d_rand != 0 ? ($urandom_range(0, 3) != 0 ? 1 : 0) : 1, 0, 0);
        end
    endtask
    initial begin
        model_reset();
        cyc = 0;
        pend = 3'b000;
        qif.req = 3'b000;
        qif.flush = 1'b0;
        qif.dn_ready = 1'b1;
        qif.q_out_enable = 1'b0;
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        pend = 3'b001;
        agents(12, 0, 0, 0);
        repeat (12) step(3'b111, 0, 1, 0, 0);
        pend = 3'b000;
        agents(8, 0, 0, 0);
        repeat (4) step(3'b010, 0, 0, 0, 0);
        pend = 3'b010;
        agents(8, 0, 0, 0);
        repeat (4) step(3'b111, 0, 1, 0, 0);
        step(3'b000, 1, 1, 0, 0);
        step(3'b000, 1, 1, 0, 0);
        pend = 3'b000;
        agents(10, 0, 0, 0);
        step(3'b100, 1, 1, 0, 0);
        agents(6, 0, 0, 0);
        step(3'b000, 0, 1, 1, 0);
        agents(4, 0, 0, 0);
        agents(40, 40, 0, 1);
        step(pend, 0, 1, 0, 1);
        pend = 3'b000;
        step(3'b000, 0, 1, 0, 0);
        agents(400, 35, 1, 1);
        pend = 3'b000;
        agents(12, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/quant_scheduler.md
QUANT_SCHEDULER -- requirements
Module: quant_scheduler

Interface
REQ-001 SHALL have parameter: LATENCY, 4, cycles from q_enable to q_out_enable of the shared 8x8 quantizer.
REQ-002 SHALL have port: clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port: req  in  3  block-ready requests, bit0=Y, bit1=Cb, bit2=Cr.
REQ-005 SHALL have port: gnt  out  3  one-hot grant, one-cycle pulse.
REQ-006 SHALL have port: q_enable  out  1  quantizer enable pulse, coincident with gnt.
REQ-007 SHALL have port: q_sel  out  2  component select for input mux and quant table (0=Y, 1=Cb, 2=Cr), valid while q_enable high.
REQ-008 SHALL have port: q_out_enable  in  1  quantizer result-valid strobe.
REQ-009 SHALL have port: dn_ready  in  1  downstream (zigzag/entropy) can accept a new block.
REQ-010 SHALL have port: res_valid  out  1  result valid, equal to q_out_enable gated by tag.
REQ-011 SHALL have port: res_comp  out  2  component ID of the current result.
REQ-012 SHALL have port: flush  in  1  stop issuing and drain.
REQ-013 SHALL have port: flush_done  out  1  one-cycle pulse when drain completes.
REQ-014 SHALL have port: busy  out  1  high when in-flight count is nonzero.
REQ-015 SHALL have port: tag_err  out  1  sticky: q_out_enable seen with no valid tag.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE: IDLE->RUN on any req; RUN->IDLE when req==0 and in-flight==0; RUN/IDLE->DRAIN on flush; DRAIN->DONE when in-flight==0; DONE->IDLE after one cycle.
REQ-017 SHALL arbitrate only in RUN with dn_ready high and flush low; flush wins over a simultaneous req.
REQ-018 SHALL register gnt, q_enable and q_sel: decision from req sampled in cycle t, outputs high in cycle t+1 only.
REQ-019 SHALL use round-robin priority starting after the last-granted component; after reset the pointer grants Y first.
REQ-020 SHALL exclude the requester granted in cycle t+1 from the decision made in that cycle; granted requester drops req in the grant cycle.
REQ-021 SHALL allow back-to-back grants to different requesters, one issue per cycle maximum.
REQ-022 SHALL push {valid=1, comp=q_sel} into a LATENCY-deep tag shift register on every q_enable, and shift an invalid entry otherwise.
REQ-023 SHALL drive res_valid=q_out_enable AND tail-valid and res_comp=tail comp combinationally from the tail entry.
REQ-024 SHALL set tag_err when q_out_enable=1 and the tail entry is invalid; cleared only by rst.
REQ-025 SHALL keep an in-flight counter (0..LATENCY) incremented on q_enable, decremented on res_valid, unchanged when both occur.
REQ-026 SHALL let issued blocks complete while dn_ready is low; dn_ready low only blocks new grants.
REQ-027 SHALL pulse flush_done exactly one cycle in DONE; a flush while in DRAIN has no further effect.

Reset
REQ-028 SHALL on rst clear gnt=0, q_enable=0, q_sel=0, res tag pipeline invalid, in-flight=0, tag_err=0, flush_done=0, state=IDLE, RR pointer=Y.
REQ-029 SHALL discard in-flight tags on a mid-operation reset; the quantizer shares rst.

Configuration
REQ-030 SHALL, when QSCHED_STATS_EN is defined, provide outputs cnt_y, cnt_cb, cnt_cr (16 bits each) counting grants per component, wrapping at 0xFFFF->0, cleared by rst; without the macro these ports and counters SHALL not exist.

Verification
REQ-031 SHALL check: reset, req=3'b001 held one cycle -> gnt=001, q_enable=1, q_sel=0 two cycles later; res_valid, res_comp=0 LATENCY cycles after.
REQ-032 SHALL check: req=3'b111 continuously -> grants Y,Cb,Cr,Y repeating, one per cycle, res_comp sequence 0,1,2,0.
REQ-033 SHALL check: dn_ready=0 with req=3'b010 -> no gnt; dn_ready=1 -> gnt=010 next cycle.
REQ-034 SHALL check: 3 blocks in flight, flush=1 -> no new gnt, flush_done pulses once after last res_valid, busy=0.
REQ-035 SHALL check: q_out_enable forced with empty pipeline -> tag_err=1, res_valid=0; rst mid-run -> all outputs zero next cycle.
